// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences one TLB maintenance op at a time (SRCH/RD/WR/FILL/INV).
// An accepted op holds the fetch path. The controller waits for in-flight data
// translations to drain, then issues a single command pulse to the translation
// unit. It returns a response (search result or error) through a valid/ready
// handshake.
//
// Ports
//   clk, resetn                 clock, async active-low reset
//   req_valid/req_ready         op handshake (ready only in IDLE)
//   req_op, req_inv_*           op code and invtlb operands
//   mem_busy                    data-side translation still in flight
//   srch_found, srch_index      TLB search result, valid the cycle after srch_fetch
//   fetch_hold                  stalls translation requests while an op is active
//   tlbwr_en, tlbfill_en, tlbrd_en, invtlb_en, srch_fetch   command pulses
//   invtlb_op/asid/vpn          registered invtlb operands
//   rand_index                  fill index, counter sampled on DRAIN exit
//   resp_valid/resp_ready       response handshake
//   resp_found, resp_index, resp_err   response payload
//
// state | meaning
// IDLE  | waiting for an op, req_ready=1
// DRAIN | op latched, waiting for mem_busy to clear
// EXEC  | one command pulse for the latched op
// SRES  | capture search result from the TLB data port
// RESP  | resp_valid held until resp_ready
module tlb_op_ctrl #(
  parameter int TLBNUM = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_inv_op,
  input  logic [9:0]  req_inv_asid,
  input  logic [18:0] req_inv_vpn,
  input  logic        mem_busy,
  input  logic        srch_found,
  input  logic [4:0]  srch_index,
  output logic        fetch_hold,
  output logic        tlbwr_en,
  output logic        tlbfill_en,
  output logic        tlbrd_en,
  output logic        invtlb_en,
  output logic        srch_fetch,
  output logic [4:0]  invtlb_op,
  output logic [9:0]  invtlb_asid,
  output logic [18:0] invtlb_vpn,
  output logic [4:0]  rand_index,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_found,
  output logic [4:0]  resp_index,
  output logic        resp_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_EXEC  = 3'd2,
    S_SRES  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [4:0] CNT_MAX = 5'(TLBNUM - 1);

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [4:0]  inv_op_q;
  logic [9:0]  inv_asid_q;
  logic [18:0] inv_vpn_q;
  logic [4:0]  cnt_q;
  logic [4:0]  rand_q;
  logic        resp_found_q;
  logic [4:0]  resp_index_q;
  logic        resp_err_q;

  logic hs;
  logic op_illegal;

  assign hs = req_valid && (state_q == S_IDLE);
  // Codes 5-7 are undefined; invtlb sub-ops above 6 are reserved.
  assign op_illegal = (op_q > OP_INV) || ((op_q == OP_INV) && (inv_op_q > 5'd6));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tlbwr_en   = 1'b0;
    tlbfill_en = 1'b0;
    tlbrd_en   = 1'b0;
    invtlb_en  = 1'b0;
    srch_fetch = 1'b0;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_DRAIN;
      S_DRAIN: if (!mem_busy) state_d = S_EXEC;
      S_EXEC: begin
        state_d = (op_q == OP_SRCH) ? S_SRES : S_RESP;
        if (!op_illegal) begin
          case (op_q)
            OP_SRCH: srch_fetch = 1'b1;
            OP_RD:   tlbrd_en   = 1'b1;
            OP_WR:   tlbwr_en   = 1'b1;
            OP_FILL: tlbfill_en = 1'b1;
            OP_INV:  invtlb_en  = 1'b1;
            default: ;
          endcase
        end
      end
      S_SRES:  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q         <= '0;
      inv_op_q     <= '0;
      inv_asid_q   <= '0;
      inv_vpn_q    <= '0;
      cnt_q        <= '0;
      rand_q       <= '0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CNT_MAX) ? 5'd0 : cnt_q + 5'd1;
      if (hs) begin
        op_q       <= req_op;
        inv_op_q   <= req_inv_op;
        inv_asid_q <= req_inv_asid;
        inv_vpn_q  <= req_inv_vpn;
      end
      if ((state_q == S_DRAIN) && !mem_busy) begin
        rand_q <= cnt_q;
      end
      if (state_q == S_EXEC) begin
        resp_err_q   <= op_illegal;
        resp_found_q <= 1'b0;
        resp_index_q <= '0;
      end
      if (state_q == S_SRES) begin
        resp_found_q <= srch_found;
        resp_index_q <= srch_index;
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign fetch_hold  = (state_q != S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_found  = resp_found_q;
  assign resp_index  = resp_index_q;
  assign resp_err    = resp_err_q;
  assign rand_index  = rand_q;
  assign invtlb_op   = inv_op_q;
  assign invtlb_asid = inv_asid_q;
  assign invtlb_vpn  = inv_vpn_q;

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 32, number of TLB entries; index width is 5 bits.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  in  1  pipeline presents a TLB maintenance op.
REQ-005 SHALL have port req_ready  out  1  controller accepts an op when high.
REQ-006 SHALL have port req_op  in  3  op code: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 illegal.
REQ-007 SHALL have port req_inv_op  in  5  invtlb sub-op.
REQ-008 SHALL have port req_inv_asid  in  10  invtlb ASID.
REQ-009 SHALL have port req_inv_vpn  in  19  invtlb VPPN.
REQ-010 SHALL have port mem_busy  in  1  a data-side translation is still in flight.
REQ-011 SHALL have port srch_found  in  1  TLB data-port hit, valid the cycle after srch_fetch.
REQ-012 SHALL have port srch_index  in  5  TLB data-port hit index, valid with srch_found.
REQ-013 SHALL have port fetch_hold  out  1  stalls instruction and data translation requests.
REQ-014 SHALL have ports tlbwr_en, tlbfill_en, tlbrd_en, invtlb_en, srch_fetch  out  1 each  single-cycle command pulses to the translation unit.
REQ-015 SHALL have ports invtlb_op  out  5, invtlb_asid  out  10, invtlb_vpn  out  19  registered invtlb operands.
REQ-016 SHALL have port rand_index  out  5  fill index, stable while tlbfill_en is high.
REQ-017 SHALL have port resp_valid  out  1  op complete; resp_ready  in  1  consumer accepts.
REQ-018 SHALL have ports resp_found  out  1, resp_index  out  5, resp_err  out  1  search result; error flag for illegal op or illegal invtlb sub-op.

Function
REQ-019 SHALL implement states IDLE, DRAIN, EXEC, SRES, RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid&&req_ready.
REQ-021 SHALL latch op and operands on handshake and go IDLE->DRAIN.
REQ-022 SHALL stay in DRAIN while mem_busy=1, then go DRAIN->EXEC.
REQ-023 SHALL drive fetch_hold=1 in every state except IDLE, combinationally from state.
REQ-024 SHALL in EXEC pulse exactly one enable for one cycle: SRCH->srch_fetch, RD->tlbrd_en, WR->tlbwr_en, FILL->tlbfill_en, INV->invtlb_en.
REQ-025 SHALL for an illegal op, or INV with inv_op>6, assert no enable in EXEC and set resp_err=1.
REQ-026 SHALL go EXEC->SRES for SRCH and EXEC->RESP for all others.
REQ-027 SHALL in SRES capture srch_found and srch_index into resp_found/resp_index, then go to RESP.
REQ-028 SHALL for non-SRCH ops set resp_found=0 and resp_index=0.
REQ-029 SHALL hold resp_valid=1 with stable resp_* in RESP until resp_ready=1, then go to IDLE.
REQ-030 SHALL run a free 5-bit counter, +1 every cycle, wrapping from TLBNUM-1 to 0.
REQ-031 SHALL drive rand_index from a copy of the counter captured on DRAIN->EXEC.
REQ-032 SHALL make minimum latency handshake->resp_valid 3 cycles for non-SRCH ops and 4 cycles for SRCH, plus one cycle per mem_busy cycle.
REQ-033 SHALL ignore req_valid outside IDLE; no queuing, at most one op outstanding.
REQ-034 SHALL apply resetn mid-operation immediately: return to IDLE, drop every pulse, and discard the op with no response.

Reset
REQ-035 SHALL while resetn=0 hold state IDLE; req_ready=1; fetch_hold, all enables, resp_valid, resp_found, resp_err =0; resp_index, rand_index, counter, invtlb_* =0.

Verification
REQ-036 SHALL cover WR with mem_busy=0: tlbwr_en high exactly one cycle, 2 cycles after handshake; resp_valid at cycle 3; fetch_hold high cycles 1-3.
REQ-037 SHALL cover SRCH where srch_found=1 and srch_index=17 in the cycle after srch_fetch: resp_found=1 and resp_index=17 at cycle 4.
REQ-038 SHALL cover FILL with mem_busy high 5 cycles: tlbfill_en delayed 5 cycles; rand_index equals the counter value at DRAIN exit; counter wraps 31->0.
REQ-039 SHALL cover INV with inv_op=7: no invtlb_en pulse; resp_err=1. INV with inv_op=2, asid=0x155: invtlb_op=2 and invtlb_asid=0x155 during the pulse.
REQ-040 SHALL cover resp_ready held low 4 cycles: resp_valid and resp_* stable, req_ready=0, and a concurrent req_valid ignored.
REQ-041 SHALL cover resetn asserted in EXEC: no further pulses; IDLE and all outputs at reset values asynchronously.
